// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control encodings and M-extension decode helpers used by the
// control unit and the execute-stage multiply/divide unit.
package muldiv_unit_pkg;

   localparam logic [4:0] ALUCTRL_ADD    = 5'd0;
   localparam logic [4:0] ALUCTRL_SUB    = 5'd1;
   localparam logic [4:0] ALUCTRL_AND    = 5'd2;
   localparam logic [4:0] ALUCTRL_OR     = 5'd3;
   localparam logic [4:0] ALUCTRL_XOR    = 5'd4;
   localparam logic [4:0] ALUCTRL_SLL    = 5'd5;
   localparam logic [4:0] ALUCTRL_SRL    = 5'd6;
   localparam logic [4:0] ALUCTRL_SRA    = 5'd7;
   localparam logic [4:0] ALUCTRL_SLT    = 5'd8;
   localparam logic [4:0] ALUCTRL_SLTU   = 5'd9;
   localparam logic [4:0] ALUCTRL_MUL    = 5'd16;
   localparam logic [4:0] ALUCTRL_MULH   = 5'd17;
   localparam logic [4:0] ALUCTRL_MULHSU = 5'd18;
   localparam logic [4:0] ALUCTRL_MULHU  = 5'd19;
   localparam logic [4:0] ALUCTRL_DIV    = 5'd20;
   localparam logic [4:0] ALUCTRL_DIVU   = 5'd21;
   localparam logic [4:0] ALUCTRL_REM    = 5'd22;
   localparam logic [4:0] ALUCTRL_REMU   = 5'd23;

   function automatic logic is_muldiv(input logic [4:0] c);
      return c inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                       ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
   endfunction

   function automatic logic is_div_op(input logic [4:0] c);
      return c inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
   endfunction

   function automatic logic is_rem_op(input logic [4:0] c);
      return c inside {ALUCTRL_REM, ALUCTRL_REMU};
   endfunction

   function automatic logic a_is_signed(input logic [4:0] c);
      return c inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
   endfunction

   function automatic logic b_is_signed(input logic [4:0] c);
      return c inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(parameter int BITS = 32);
   logic            valid_i;
   logic [4:0]      alu_ctrl_i;
   logic [BITS-1:0] op_a_i;
   logic [BITS-1:0] op_b_i;
   logic            flush_i;
   logic            stall_o;
   logic            busy_o;
   logic            done_o;
   logic [BITS-1:0] result_o;

   modport master (output valid_i, alu_ctrl_i, op_a_i, op_b_i, flush_i,
                   input  stall_o, busy_o, done_o, result_o);
   modport slave  (input  valid_i, alu_ctrl_i, op_a_i, op_b_i, flush_i,
                   output stall_o, busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_unit_datapath.sv
// Shared accumulator/remainder shift register for shift-add multiply and
// restoring divide, with operand sign conditioning and final negation.
module muldiv_unit_datapath
   import muldiv_unit_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [4:0]      op_i,
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic            special_o,
   output logic [BITS-1:0] special_res_o,
   output logic [BITS-1:0] final_res_o
);
   localparam logic [BITS-1:0] ZERO = '0;
   localparam logic [BITS-1:0] ONES = '1;
   localparam logic [BITS-1:0] MIN  = {1'b1, {(BITS-1){1'b0}}};

   logic              a_neg_s, b_neg_s;
   logic [BITS-1:0]   mag_a_s, mag_b_s;
   logic [2*BITS-1:0] acc_q, acc_d, acc_step_s, prod_s;
   logic [BITS-1:0]   b_q, b_d;
   logic [4:0]        op_q, op_d;
   logic              neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic [BITS:0]     sum_s, shifted_s, diff_s;
   logic              ge_s;
   logic [BITS-1:0]   rem_new_s, quo_s, rem_s;

   // Operand magnitudes per signedness; -MIN stays MIN, which is the correct magnitude.
   always_comb begin
      a_neg_s = a_is_signed(op_i) & a_i[BITS-1];
      b_neg_s = b_is_signed(op_i) & b_i[BITS-1];
      mag_a_s = a_neg_s ? (ZERO - a_i) : a_i;
      mag_b_s = b_neg_s ? (ZERO - b_i) : b_i;
   end

   // Divide-by-zero and signed overflow resolve without iterating.
   always_comb begin
      special_o     = 1'b0;
      special_res_o = ZERO;
      if (is_div_op(op_i) && (b_i == ZERO)) begin
         special_o     = 1'b1;
         special_res_o = is_rem_op(op_i) ? a_i : ONES;
      end else if (is_div_op(op_i) && a_is_signed(op_i) && (a_i == MIN) && (b_i == ONES)) begin
         special_o     = 1'b1;
         special_res_o = is_rem_op(op_i) ? ZERO : MIN;
      end else begin
         special_o     = 1'b0;
      end
   end

   // One iteration: multiply keeps {hi, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      sum_s     = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, b_q} : {1'b0, ZERO});
      shifted_s = {acc_q[2*BITS-1:BITS], acc_q[BITS-1]};
      ge_s      = (shifted_s >= {1'b0, b_q});
      diff_s    = shifted_s - {1'b0, b_q};
      rem_new_s = ge_s ? diff_s[BITS-1:0] : shifted_s[BITS-1:0];
      if (is_div_op(op_q)) begin
         acc_step_s = {rem_new_s, acc_q[BITS-2:0], ge_s};
      end else begin
         acc_step_s = {sum_s, acc_q[BITS-1:1]};
      end
   end

   // Result of the final step, sign-corrected and half-selected.
   always_comb begin
      prod_s = neg_q ? (-acc_step_s) : acc_step_s;
      quo_s  = acc_step_s[BITS-1:0];
      rem_s  = acc_step_s[2*BITS-1:BITS];
      case (op_q)
         ALUCTRL_MUL:                                final_res_o = prod_s[BITS-1:0];
         ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU: final_res_o = prod_s[2*BITS-1:BITS];
         ALUCTRL_DIV, ALUCTRL_DIVU:                  final_res_o = neg_q ? (ZERO - quo_s) : quo_s;
         ALUCTRL_REM, ALUCTRL_REMU:                  final_res_o = neg_rem_q ? (ZERO - rem_s) : rem_s;
         default:                                    final_res_o = ZERO;
      endcase
   end

   // Capture conditioned operands on accept, advance one bit per iterating cycle.
   always_comb begin
      acc_d     = acc_q;
      b_d       = b_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      if (load_i) begin
         op_d      = op_i;
         neg_d     = a_neg_s ^ b_neg_s;
         neg_rem_d = a_neg_s;
         if (is_div_op(op_i)) begin
            b_d   = mag_b_s;
            acc_d = {ZERO, mag_a_s};
         end else begin
            b_d   = mag_a_s;
            acc_d = {ZERO, mag_b_s};
         end
      end else if (step_i) begin
         acc_d = acc_step_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= {2*BITS{1'b0}};
         b_q       <= ZERO;
         op_q      <= 5'd0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         b_q       <= b_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and result
// register; the arithmetic lives in muldiv_unit_datapath.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave md
);
   localparam int CW = $clog2(BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] result_q, result_d;
   logic            is_md_s, accept_s, load_s, step_s, special_s;
   logic [BITS-1:0] special_res_s, final_res_s;

   assign is_md_s  = is_muldiv(md.alu_ctrl_i);
   assign accept_s = md.valid_i & is_md_s & ~md.flush_i;

   muldiv_unit_datapath #(.BITS(BITS)) u_datapath (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load_s),
      .step_i        (step_s),
      .op_i          (md.alu_ctrl_i),
      .a_i           (md.op_a_i),
      .b_i           (md.op_b_i),
      .special_o     (special_s),
      .special_res_o (special_res_s),
      .final_res_o   (final_res_s)
   );

   // Next-state, counter and result selection; flush beats accept and iteration.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      load_s   = 1'b0;
      step_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               load_s = 1'b1;
               cnt_d  = CW'(BITS);
               if (special_s) begin
                  state_d  = ST_DONE;
                  result_d = special_res_s;
               end else if (is_div_op(md.alu_ctrl_i)) begin
                  state_d = ST_DIV;
               end else begin
                  state_d = ST_MUL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL, ST_DIV: begin
            if (md.flush_i) begin
               state_d = ST_IDLE;
            end else begin
               step_s = 1'b1;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d  = ST_DONE;
                  result_d = final_res_s;
               end else begin
                  state_d = state_q;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // A flushed instruction in DONE must not retire, so done is masked by flush.
   assign md.stall_o  = md.valid_i & is_md_s & (state_q != ST_DONE) & ~md.flush_i;
   assign md.busy_o   = (state_q != ST_IDLE);
   assign md.done_o   = (state_q == ST_DONE) & ~md.flush_i;
   assign md.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results from an
// arithmetic reference model, a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   int   done_cyc[$];
   logic [31:0] last_res = 32'h0;

   muldiv_unit_if #(.BITS(32)) bus ();

   muldiv_unit #(.BITS(32)) dut (
      .clk (clk),
      .rst (rst),
      .md  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!(op inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU})) return 1'b0;
      if (b == 32'h0) return 1'b1;
      return (op inside {ALUCTRL_DIV, ALUCTRL_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      logic signed [31:0] sa, sb, sq;
      sa = a;
      sb = b;
      case (op)
         ALUCTRL_MUL:    begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[31:0]; end
         ALUCTRL_MULH:   begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
         ALUCTRL_MULHSU: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return ps[63:32]; end
         ALUCTRL_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
         ALUCTRL_DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sq = sa / sb;
            return sq;
         end
         ALUCTRL_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sq = sa % sb;
            return sq;
         end
         ALUCTRL_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         ALUCTRL_REMU: return (b == 32'h0) ? a : a % b;
         default:      return 32'h0;
      endcase
   endfunction

   // Issue one M op, hold it while stalled, then free the pipeline slot.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
      exp_t e;
      int   n;
      bus.valid_i    = 1'b1;
      bus.alu_ctrl_i = op;
      bus.op_a_i     = a;
      bus.op_b_i     = b;
      e.res   = expv;
      e.lat   = is_special(op, a, b) ? 1 : 33;
      e.issue = cyc;
      sb_q.push_back(e);
      #1;
      chk("stall_accept", {63'h0, bus.stall_o}, 64'h1);
      n = 0;
      while (bus.stall_o === 1'b1 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("stall_cycles", n, e.lat);
      last_res = expv;
      @(negedge clk);
      bus.valid_i = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always begin
      @(negedge clk);
      #2;
      if (!rst && bus.done_o === 1'b1) begin
         done_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'h1, 64'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", {32'h0, bus.result_o}, {32'h0, e.res});
            chk("latency", cyc - e.issue, e.lat);
         end
      end
   end

   localparam logic [4:0] M_OPS [8] = '{ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                                        ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
   localparam logic [4:0]  D_OP [11] = '{ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHU, ALUCTRL_MULHSU,
                                         ALUCTRL_DIV, ALUCTRL_REM, ALUCTRL_DIVU, ALUCTRL_DIV,
                                         ALUCTRL_REMU, ALUCTRL_DIV, ALUCTRL_REM};
   localparam logic [31:0] D_A [11] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h5,
                                        32'h5, 32'h8000_0000, 32'h8000_0000};
   localparam logic [31:0] D_B [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'h2, 32'h2, 32'h2, 32'h0,
                                        32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [31:0] D_R [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                        32'h5, 32'h8000_0000, 32'h0};

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] a, b;
      bus.valid_i    = 1'b0;
      bus.alu_ctrl_i = ALUCTRL_ADD;
      bus.op_a_i     = 32'h0;
      bus.op_b_i     = 32'h0;
      bus.flush_i    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_busy",   {63'h0, bus.busy_o},  64'h0);
      chk("reset_done",   {63'h0, bus.done_o},  64'h0);
      chk("reset_stall",  {63'h0, bus.stall_o}, 64'h0);
      chk("reset_result", {32'h0, bus.result_o}, 64'h0);

      // Non-M code is ignored.
      @(negedge clk);
      bus.valid_i    = 1'b1;
      bus.alu_ctrl_i = ALUCTRL_ADD;
      bus.op_a_i     = 32'h1234;
      bus.op_b_i     = 32'h5678;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("add_stall", {63'h0, bus.stall_o}, 64'h0);
         @(negedge clk);
         #1;
         chk("add_busy", {63'h0, bus.busy_o}, 64'h0);
         @(negedge clk);
      end
      bus.valid_i = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_op(D_OP[i], D_A[i], D_B[i], D_R[i]);

      // Back-to-back MULs: second accepted right after the first's DONE.
      run_op(ALUCTRL_MUL, 32'd12, 32'd34, 32'd408);
      run_op(ALUCTRL_MUL, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF7);
      if (done_cyc.size() >= 2) chk("b2b_gap", done_cyc[$] - done_cyc[$-1], 34);
      else chk("b2b_done_count", done_cyc.size(), 2);

      // Flush a DIV at cycle 10.
      bus.valid_i    = 1'b1;
      bus.alu_ctrl_i = ALUCTRL_DIV;
      bus.op_a_i     = 32'd100;
      bus.op_b_i     = 32'd7;
      repeat (10) @(negedge clk);
      bus.flush_i = 1'b1;
      #1;
      chk("flush_stall", {63'h0, bus.stall_o}, 64'h0);
      @(negedge clk);
      bus.flush_i = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      chk("flush_busy",   {63'h0, bus.busy_o},  64'h0);
      chk("flush_done",   {63'h0, bus.done_o},  64'h0);
      chk("flush_result", {32'h0, bus.result_o}, {32'h0, last_res});
      run_op(ALUCTRL_MUL, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0100);

      // Reset in the middle of a DIV.
      bus.valid_i    = 1'b1;
      bus.alu_ctrl_i = ALUCTRL_DIV;
      bus.op_a_i     = 32'd1000;
      bus.op_b_i     = 32'd3;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      chk("rst_busy",   {63'h0, bus.busy_o},  64'h0);
      chk("rst_done",   {63'h0, bus.done_o},  64'h0);
      chk("rst_stall",  {63'h0, bus.stall_o}, 64'h0);
      chk("rst_result", {32'h0, bus.result_o}, 64'h0);
      last_res = 32'h0;
      @(negedge clk);

      // Randomized ops, biased toward the divide corner cases.
      for (int i = 0; i < 40; i++) begin
         op = M_OPS[$urandom_range(0, 7)];
         case ($urandom_range(0, 5))
            0:       begin a = $urandom; b = 32'h0; end
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
            3:       begin a = -$urandom_range(0, 255); b = -$urandom_range(1, 15); end
            default: begin a = $urandom; b = $urandom; end
         endcase
         run_op(op, a, b, ref_model(op, a, b));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit for the RV32M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits in the execute stage beside the single-cycle ALU and consumes the control unit's 5-bit ALU control code.
- Stalls the pipeline while an operation iterates, then returns a BITS-wide result.

Parameters:
BITS, 32, operand/result width; iteration count equals BITS.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
valid_i  input  1  execute stage holds a live instruction
alu_ctrl_i  input  5  ALUCTRL_* code from the control unit
op_a_i  input  BITS  rs1 value (multiplicand/dividend)
op_b_i  input  BITS  rs2 value (multiplier/divisor)
flush_i  input  1  kill the in-flight operation (branch mispredict/redirect)
stall_o  output  1  hold all upstream pipeline registers
busy_o  output  1  FSM is not in IDLE
done_o  output  1  one-cycle pulse; result_o valid this cycle
result_o  output  BITS  result, held until the next done_o

Behaviour:
- Reset: state IDLE, busy_o=0, done_o=0, result_o=0, internal counter/registers 0.
- Priority order: rst, then flush_i, then accept.
- is_md = alu_ctrl_i is one of the eight M-extension codes. All other codes are ignored and never stall.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE -> MUL/DIV when valid_i & is_md & !flush_i.
  - On this accept edge, op_a_i, op_b_i and alu_ctrl_i are captured, and counter is loaded with BITS.
  - Later input changes are ignored until DONE.
- Operand conditioning:
  - Operands are converted to magnitudes per signedness.
  - Signedness of a: MUL, MULH, MULHSU, DIV, REM.
  - Signedness of b: MUL, MULH, DIV, REM.
- MUL state: radix-2 shift-add over a 2*BITS accumulator, one bit per cycle, BITS cycles.
  - Product is negated if operand signs differ.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV state: restoring shift-subtract, one quotient bit per cycle, BITS cycles.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
- Special cases bypass iteration and go IDLE -> DONE directly (latency 1):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (a = 0x80..0, b = -1): DIV returns 0x80..0; REM returns 0.
- Counter decrements each iterating cycle. At counter==1, the next state is DONE and result_o is registered on that edge.
- Normal latency: accept edge, then BITS iterating cycles, then DONE. done_o is high in cycle BITS+1 after accept (33 for BITS=32).
- DONE: done_o=1, result_o valid. Unconditionally goes to IDLE next cycle.
- stall_o = valid_i & is_md & (state != DONE) & !flush_i (combinational).
  - In the accept cycle, stall_o is already 1.
  - In DONE, stall_o is 0, so the pipeline advances the same cycle.
- Back-to-back M ops: the next op is accepted the cycle after DONE, with no gap beyond that.
- flush_i in MUL/DIV/DONE: next state IDLE, done_o stays 0, result_o unchanged.
- rst mid-operation: identical to the reset values above; no done_o.
- busy_o = (state != IDLE).

Decomposition:
- Shared include (alu_control_def.v): ALUCTRL_MUL..ALUCTRL_REMU encodings plus an is_muldiv macro or function, so control and execute agree.
- FSM state encodings are local parameters.
- One natural sub-module, muldiv_datapath: accumulator/remainder shift register, add/subtract step, sign conditioning and final negation. The FSM and counter stay in muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD: stall_o=1 for cycles 0..32, done_o at cycle 33, result_o=0xFFFFFFEB, stall_o=0 at cycle 33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. Each has done_o at cycle 33.
- Corner cases, each with done_o at cycle 1 and no 32-cycle stall:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- flush_i asserted at cycle 10 of a DIV: no done_o, busy_o=0 next cycle, prior result_o retained. A MUL presented the following cycle is accepted and completes normally. Repeat with rst at cycle 10: all outputs return to reset values.
- valid_i=1 with ALUCTRL_ADD: stall_o=0, busy_o=0, no done_o. Two consecutive MULs: the second is accepted in the cycle after the first's DONE, with done pulses 34 cycles apart.
